// File: rtl/sync_multi.sv
// sync_multi -- multi-channel level synchronizer with optional stability filter
//
// Each channel passes its asynchronous input through a STAGES-deep flop chain.
// With SYNC_MULTI_FILTER_EN defined, the synchronized level must hold for
// FILTER_CNT consecutive cycles before it is adopted on sync_out. Without it,
// sync_out follows the last chain stage every cycle and FILTER_CNT is unused.
//
// Parameters:
//   WIDTH      number of independent channels (1..32)
//   STAGES     synchronizer flops per channel (2..4)
//   FILTER_CNT stable cycles required before sync_out changes (1..255)
//   RST_VAL    reset value of every per-channel state bit
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous, active-high reset
//   async_in  in   [WIDTH] asynchronous level inputs
//   sync_out  out  [WIDTH] synchronized, filtered level (registered)
//   rise      out  [WIDTH] one-cycle pulse on sync_out 0->1
//   fall      out  [WIDTH] one-cycle pulse on sync_out 1->0
//   changed   out  OR-reduction of rise | fall
//
// Configuration macro: SYNC_MULTI_FILTER_EN
module sync_multi #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      STAGES     = 2,
  parameter int unsigned      FILTER_CNT = 4,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        chain[k] <= RST_VAL;
      end
    end else begin
      chain[0] <= async_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
        chain[k] <= chain[k-1];
      end
    end
  end

  assign s = chain[STAGES-1];

`ifdef SYNC_MULTI_FILTER_EN
  localparam int unsigned          CNT_W    = $clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_CNT - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // Counter reaching FILTER_CNT-1 while still differing is the same as
  // cnt+1 == FILTER_CNT; it clears on adoption, so it never passes CNT_LAST.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (rst) begin
        cnt[i]      <= '0;
        sync_out[i] <= RST_VAL[i];
      end else if (s[i] == sync_out[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_LAST) begin
        sync_out[i] <= s[i];
        cnt[i]      <= '0;
      end else begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end
`else
  // FILTER_CNT has no effect without the filter.
  logic unused_filter_cnt;
  assign unused_filter_cnt = (FILTER_CNT == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out <= RST_VAL;
    end else begin
      sync_out <= s;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= RST_VAL;
    end else begin
      prev <= sync_out;
    end
  end

  // prev and sync_out reset to the same value, so leaving reset is pulse-free.
  assign rise    = sync_out & ~prev;
  assign fall    = ~sync_out & prev;
  assign changed = |(rise | fall);

endmodule

// File: tb/tb_sync_multi.sv
// tb_sync_multi -- directed self-checking bench for sync_multi.
// dut_a uses RST_VAL 8'h00, dut_b uses RST_VAL 8'hFF. Expected latencies
// follow the build: STAGES+FILTER_CNT with the filter, STAGES+1 without.
module tb_sync_multi;

  localparam int unsigned ST = 2;
  localparam int unsigned FC = 4;
`ifdef SYNC_MULTI_FILTER_EN
  localparam bit          FILT = 1'b1;
  localparam int unsigned LAT  = ST + FC;
`else
  localparam bit          FILT = 1'b0;
  localparam int unsigned LAT  = ST + 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ain_a = 8'h00;
  logic [7:0] ain_b = 8'hFF;
  logic [7:0] out_a, rise_a, fall_a;
  logic [7:0] out_b, rise_b, fall_b;
  logic       chg_a, chg_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_multi #(.WIDTH(8), .STAGES(ST), .FILTER_CNT(FC), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .async_in(ain_a),
    .sync_out(out_a), .rise(rise_a), .fall(fall_a), .changed(chg_a)
  );

  sync_multi #(.WIDTH(8), .STAGES(ST), .FILTER_CNT(FC), .RST_VAL(8'hFF)) dut_b (
    .clk(clk), .rst(rst), .async_in(ain_b),
    .sync_out(out_b), .rise(rise_b), .fall(fall_b), .changed(chg_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] e_out,
                         input logic [7:0] e_rise, input logic [7:0] e_fall);
    chk({tag, ".sync_out"}, out_a, e_out);
    chk({tag, ".rise"}, rise_a, e_rise);
    chk({tag, ".fall"}, fall_a, e_fall);
    chk({tag, ".changed"}, {7'd0, chg_a}, {7'd0, |(e_rise | e_fall)});
  endtask

  task automatic check_b(input string tag);
    chk({tag, ".b_sync_out"}, out_b, 8'hFF);
    chk({tag, ".b_rise"}, rise_b, 8'h00);
    chk({tag, ".b_fall"}, fall_b, 8'h00);
    chk({tag, ".b_changed"}, {7'd0, chg_b}, 8'h00);
  endtask

  initial begin
    logic [7:0] e_out, e_r, e_f;

    // Reset state of both instances.
    step();
    step();
    check_a("reset", 8'h00, 8'h00, 8'h00);
    check_b("reset");

    // Leaving reset: no pulses on either instance.
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      check_a("post_reset", 8'h00, 8'h00, 8'h00);
      check_b("post_reset");
    end

    // Single channel 0->1, exact latency, one-cycle rise.
    ain_a = 8'h01;
    for (int n = 1; n <= int'(LAT) + 2; n++) begin
      step();
      e_out = (n >= int'(LAT)) ? 8'h01 : 8'h00;
      e_r   = (n == int'(LAT)) ? 8'h01 : 8'h00;
      check_a("rise01", e_out, e_r, 8'h00);
    end

    // Bit 3 high for 3 cycles: filtered away, or passed through unfiltered.
    ain_a = 8'h09;
    for (int n = 1; n <= 10; n++) begin
      step();
      e_out = 8'h01; e_r = 8'h00; e_f = 8'h00;
      if (!FILT) begin
        if (n >= int'(ST) + 1 && n <= int'(ST) + 3) e_out = 8'h09;
        if (n == int'(ST) + 1) e_r = 8'h08;
        if (n == int'(ST) + 4) e_f = 8'h08;
      end
      check_a("glitch3", e_out, e_r, e_f);
      if (n == 3) ain_a = 8'h01;
    end

    // All high, then upper nibble falls together.
    ain_a = 8'hFF;
    for (int n = 1; n <= int'(LAT) + 1; n++) step();
    check_a("all_high", 8'hFF, 8'h00, 8'h00);
    ain_a = 8'h0F;
    for (int n = 1; n <= int'(LAT) + 1; n++) begin
      step();
      e_out = (n >= int'(LAT)) ? 8'h0F : 8'hFF;
      e_f   = (n == int'(LAT)) ? 8'hF0 : 8'h00;
      check_a("fall_f0", e_out, 8'h00, e_f);
    end

    // Reset mid-count restarts the full latency.
    ain_a = 8'h00;
    for (int n = 1; n <= int'(LAT) + 1; n++) step();
    check_a("settle0", 8'h00, 8'h00, 8'h00);
    ain_a = 8'h80;
    for (int n = 1; n <= 3; n++) begin
      step();
      e_out = (n >= int'(LAT)) ? 8'h80 : 8'h00;
      e_r   = (n == int'(LAT)) ? 8'h80 : 8'h00;
      check_a("pre_rst", e_out, e_r, 8'h00);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_a("mid_rst", 8'h00, 8'h00, 8'h00);
    for (int n = 1; n <= int'(LAT) + 1; n++) begin
      step();
      e_out = (n >= int'(LAT)) ? 8'h80 : 8'h00;
      e_r   = (n == int'(LAT)) ? 8'h80 : 8'h00;
      check_a("after_rst", e_out, e_r, 8'h00);
    end

    // 1-cycle glitch on bit 0.
    ain_a = 8'h81;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 1) ain_a = 8'h80;
      e_out = 8'h80; e_r = 8'h00; e_f = 8'h00;
      if (!FILT) begin
        if (n == int'(ST) + 1) begin e_out = 8'h81; e_r = 8'h01; end
        if (n == int'(ST) + 2) e_f = 8'h01;
      end
      check_a("glitch1", e_out, e_r, e_f);
    end

    // Several channels change in the same cycle.
    ain_a = 8'h00;
    for (int n = 1; n <= int'(LAT) + 1; n++) step();
    check_a("settle1", 8'h00, 8'h00, 8'h00);
    ain_a = 8'hA5;
    for (int n = 1; n <= int'(LAT) + 1; n++) begin
      step();
      e_out = (n >= int'(LAT)) ? 8'hA5 : 8'h00;
      e_r   = (n == int'(LAT)) ? 8'hA5 : 8'h00;
      check_a("multi_a5", e_out, e_r, 8'h00);
    end

    check_b("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_multi.md
SYNC_MULTI -- requirements
Module: sync_multi

Interface
REQ-001 Parameter WIDTH, default 8, number of independent channels; legal 1..32.
REQ-002 Parameter STAGES, default 2, synchronizer flops per channel; legal 2..4.
REQ-003 Parameter FILTER_CNT, default 4, consecutive stable cycles required before the output changes; legal 1..255.
REQ-004 Parameter RST_VAL, default all-zero, WIDTH bits, reset value of every per-channel state bit.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port async_in  input  WIDTH  asynchronous level inputs, one per channel.
REQ-008 Port sync_out  output  WIDTH  synchronized, filtered level, registered.
REQ-009 Port rise  output  WIDTH  one-cycle pulse on each sync_out 0->1 transition.
REQ-010 Port fall  output  WIDTH  one-cycle pulse on each sync_out 1->0 transition.
REQ-011 Port changed  output  1  OR-reduction of (rise | fall).

Function
REQ-012 Each channel SHALL pass async_in[i] through a chain of STAGES flops; the last stage is s[i]; there is no logic between chain flops.
REQ-013 Each channel SHALL hold a counter cnt[i] of width ceil(log2(FILTER_CNT+1)).
REQ-014 If s[i] == sync_out[i], cnt[i] SHALL clear to 0 on the next edge.
REQ-015 If s[i] != sync_out[i] and cnt[i]+1 < FILTER_CNT, cnt[i] SHALL increment.
REQ-016 If s[i] != sync_out[i] and cnt[i]+1 == FILTER_CNT, sync_out[i] SHALL load s[i] and cnt[i] SHALL clear.
REQ-017 Latency from the first edge sampling a new stable async_in value to sync_out showing it SHALL be exactly STAGES+FILTER_CNT edges.
REQ-018 A level at s[i] lasting fewer than FILTER_CNT cycles SHALL leave sync_out[i] unchanged and produce no rise/fall pulse.
REQ-019 A register prev[i] SHALL capture sync_out[i] every cycle; rise = sync_out & ~prev, fall = ~sync_out & prev.
REQ-020 rise[i]/fall[i] SHALL be high for exactly one cycle, coincident with the first cycle sync_out[i] holds the new value; rise and fall of one channel are never simultaneously high.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels each produce their own pulse in the same cycle.
REQ-022 The counter SHALL never exceed FILTER_CNT-1 and SHALL never wrap.

Reset
REQ-023 On a rising clk edge with rst high, all chain flops, sync_out and prev SHALL load RST_VAL, and all cnt SHALL load 0.
REQ-024 rst SHALL take priority over every other update, including a filter completion in the same cycle.
REQ-025 rise, fall and changed SHALL be 0 from the first cycle after a reset edge; leaving reset generates no pulse.
REQ-026 Reset asserted mid-count SHALL discard the partial count; a pending transition SHALL restart its full STAGES+FILTER_CNT latency after reset deasserts.

Configuration
REQ-027 Macro SYNC_MULTI_FILTER_EN defined: the filter (REQ-013..REQ-018, REQ-022) SHALL be compiled in as specified.
REQ-028 SYNC_MULTI_FILTER_EN undefined: no counters SHALL exist; sync_out[i] SHALL load s[i] every edge, latency STAGES+1 edges; FILTER_CNT is ignored; all other requirements hold.

Verification (WIDTH=8, STAGES=2, FILTER_CNT=4, RST_VAL=8'h00, filter enabled unless stated)
REQ-029 Reset, then async_in 8'h00->8'h01 held -> sync_out==8'h01 exactly 6 edges later; rise==8'h01 and changed==1 for one cycle only.
REQ-030 async_in[3] high for 3 cycles, then low -> sync_out, rise, fall and changed stay 0 throughout.
REQ-031 sync_out==8'hFF, async_in->8'h0F held -> after 6 edges sync_out==8'h0F; fall==8'hF0 for one cycle; rise==0.
REQ-032 async_in 8'h00->8'h80, rst pulsed high for 1 cycle at edge 4 -> sync_out stays 8'h00 until 6 edges after rst deasserts, then 8'h80 with a single rise pulse.
REQ-033 Filter disabled: async_in 8'h00->8'hA5 -> sync_out==8'hA5 after 3 edges; 1-cycle glitch on bit 0 passes through with matching rise/fall pulses.
REQ-034 Leave reset with RST_VAL=8'hFF and async_in=8'hFF -> no rise/fall/changed pulse in any cycle.
